rr_arbiter_8: RTL
=================

// Module: rr_arbiter_8
// PURPOSE
//   Round-robin arbiter sharing one 3-to-8 decoded resource among 8 requesters.
//   Selects one requester, presents its 3-bit index (drives decoder a2..a0) and
//   a registered one-hot grant (equivalent to decoder i7..i0 outputs).
//   Holds the grant until the owner releases it, then rotates priority.
//   Sits between requester clients and the decoder-selected shared line.
// PARAMETERS
//   HOLD_MAX  16  max GRANT cycles per ownership when RR_TIMEOUT_EN defined; legal >= 2
//   CNT_W     5   hold-counter width; must satisfy 2**CNT_W > HOLD_MAX
// PORTS
//   clk        in   1  single clock, all state updates on rising edge
//   reset      in   1  synchronous, active-high reset
//   req        in   8  request vector, bit n = requester n
//   done       in   1  owner release pulse; sampled only in GRANT
//   gnt        out  8  one-hot grant, registered; 8'h00 when idle
//   gnt_idx    out  3  binary index of owner {a2,a1,a0}; 3'd0 when idle
//   gnt_valid  out  1  1 while in GRANT
//   timeout    out  1  1-cycle pulse on forced release (0 without macro)
// BEHAVIOUR
//   - Reset (sync): state=IDLE, ptr=0, hold_cnt=0, gnt=0, gnt_idx=0,
//     gnt_valid=0, timeout=0. Reset mid-GRANT drops grant at that same edge.
//   - States: IDLE, GRANT. All outputs registered.
//   - IDLE: if req!=0, winner = first set bit of req searching ptr, ptr+1, ...,
//     ptr+7 (mod 8). Next edge: state=GRANT, gnt=1<<winner, gnt_idx=winner,
//     gnt_valid=1, hold_cnt=1. Latency req->gnt = 1 cycle. If req==0 stay IDLE.
//   - GRANT: grant held constant. Release when done=1 OR req[gnt_idx]=0.
//     On release edge: state=IDLE, gnt=0, gnt_idx=0, gnt_valid=0,
//     ptr=gnt_idx+1 (3-bit wrap, 7->0), hold_cnt=0.
//   - Mandatory one-cycle idle gap between grants: gnt never changes owner
//     directly; release->next grant = 2 cycles min. Guarantees no overlap on
//     the decoded line.
//   - Simultaneous done and req drop: single release. done in IDLE ignored.
//   - Requests from other bits during GRANT do not preempt; they are
//     evaluated in the IDLE cycle after release with the rotated ptr.
//   - Owner re-asserting req in the gap cycle competes normally; being lowest
//     priority after rotation, it only wins if no other req is set.
//   - gnt is always 0 or exactly one-hot; gnt == (1<<gnt_idx) when gnt_valid.
//   - hold_cnt increments each GRANT cycle, saturating at HOLD_MAX.
// CONFIGURATION
//   RR_TIMEOUT_EN defined: if in GRANT with hold_cnt==HOLD_MAX and no
//     normal release, force release on that edge (same actions as release,
//     ptr rotates) and pulse timeout=1 for the following cycle. Normal release
//     on the same cycle takes precedence: no timeout pulse.
//   RR_TIMEOUT_EN undefined: no forced release; grant held indefinitely until
//     done/req drop; timeout tied to 0; hold_cnt may be removed.
// TESTING
//   1. reset=1 two cycles, req=8'hFF -> gnt=8'h00, gnt_idx=0, gnt_valid=0.
//   2. ptr=0, req=8'h81 -> next cycle gnt=8'h01 idx=0; pulse done -> gap cycle
//      gnt=0; then gnt=8'h80 idx=7; done -> gap, gnt=8'h01 idx=0 (wrap).
//   3. req=8'hFF constant, done pulsed each GRANT cycle -> idx sequence
//      0,1,2,...,7,0 with gnt=0 between each grant.
//   4. Owner idx 3 drops req[3] with done=0 -> release next edge, ptr=4;
//      req=8'h18 then -> grant idx 4.
//   5. RR_TIMEOUT_EN, HOLD_MAX=4, req=8'h04 held, done=0 -> gnt=8'h04 for 4
//      cycles, timeout=1 one cycle with gnt=0, then gnt=8'h04 again.
//   6. reset=1 during GRANT idx 5 -> next edge gnt=0, ptr=0; req=8'h21 ->
//      grant idx 0.

Source files
------------

// File: rtl/rr_arbiter_8.sv
// Round-robin arbiter for 8 requesters sharing one 3-to-8 decoded line.
// Optional forced release after HOLD_MAX grant cycles when RR_TIMEOUT_EN is defined.
module rr_arbiter_8 #(
    parameter int unsigned HOLD_MAX = 16,
    parameter int unsigned CNT_W    = 5
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [7:0] req_i,
    input  logic       done_i,
    output logic [7:0] gnt_o,
    output logic [2:0] gnt_idx_o,
    output logic       gnt_valid_o,
    output logic       timeout_o
);

    typedef enum logic [0:0] {StIdle, StGrant} state_e;

    localparam logic [CNT_W-1:0] HoldMax = CNT_W'(HOLD_MAX);

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [7:0]       gnt_q, gnt_d;
    logic [2:0]       gnt_idx_q, gnt_idx_d;
    logic             timeout_q, timeout_d;

    logic [2:0] win;
    logic       found;
    logic [2:0] cand;
    logic       release_ok;
    logic       force_rel;

    // Rotating priority search starting at ptr_q.
    always_comb begin
        win   = 3'd0;
        found = 1'b0;
        cand  = 3'd0;
        for (int i = 0; i < 8; i++) begin
            cand = ptr_q + 3'(i);
            if (!found && req_i[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign release_ok = done_i || !req_i[gnt_idx_q];

`ifdef RR_TIMEOUT_EN
    assign force_rel = (hold_cnt_q == HoldMax);
`else
    assign force_rel = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        hold_cnt_d = hold_cnt_q;
        gnt_d      = gnt_q;
        gnt_idx_d  = gnt_idx_q;
        timeout_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (found) begin
                    state_d    = StGrant;
                    gnt_d      = 8'b1 << win;
                    gnt_idx_d  = win;
                    hold_cnt_d = CNT_W'(1);
                end
            end
            StGrant: begin
                if (release_ok || force_rel) begin
                    state_d    = StIdle;
                    gnt_d      = 8'h00;
                    gnt_idx_d  = 3'd0;
                    ptr_d      = gnt_idx_q + 3'd1;
                    hold_cnt_d = '0;
                    // Normal release wins, so the pulse only marks a true forced release.
                    timeout_d  = !release_ok;
                end else if (hold_cnt_q != HoldMax) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= StIdle;
            ptr_q      <= 3'd0;
            hold_cnt_q <= '0;
            gnt_q      <= 8'h00;
            gnt_idx_q  <= 3'd0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            hold_cnt_q <= hold_cnt_d;
            gnt_q      <= gnt_d;
            gnt_idx_q  <= gnt_idx_d;
            timeout_q  <= timeout_d;
        end
    end

    assign gnt_o       = gnt_q;
    assign gnt_idx_o   = gnt_idx_q;
    assign gnt_valid_o = (state_q == StGrant);
    assign timeout_o   = timeout_q;

endmodule
